// File: rtl/sine_sample_requester_pkg.sv
// ---------------------------------------------------------------------------
// sine_sample_requester_pkg : shared widths and request FSM encoding
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sine_sample_requester_pkg;
  localparam int SAMPLE_W = 16;
  localparam int STEP_W   = 20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } req_state_t;
endpackage

`default_nettype wire

// File: rtl/sine_sample_requester_fifo.sv
// ---------------------------------------------------------------------------
// sample_fifo : synchronous FIFO with combinational head and occupancy count
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage is left unreset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: rtl/sine_sample_requester.sv
// ---------------------------------------------------------------------------
// sine_sample_requester : requests sine samples, buffers them, serves the codec
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sine_sample_requester
  import sine_sample_requester_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 7
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          play,
  input  logic [STEP_W-1:0]             step_size_in,
  output logic                          generate_next,
  output logic [STEP_W-1:0]             step_size,
  input  logic                          sample_ready,
  input  logic [SAMPLE_W-1:0]           sample,
  input  logic                          codec_request,
  output logic [SAMPLE_W-1:0]           codec_sample,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic                          timeout_err
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  req_state_t            state;
  req_state_t            state_nxt;
  logic [CNT_W-1:0]      wait_cnt;
  logic [CNT_W-1:0]      wait_cnt_nxt;
  logic                  load_step;
  logic                  push;
  logic [SAMPLE_W-1:0]   push_data;
  logic                  timeout_hit;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [SAMPLE_W-1:0]   fifo_head;

  assign generate_next = (state == ST_REQ);
  assign pop           = codec_request && !fifo_empty;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    load_step    = 1'b0;
    push         = 1'b0;
    push_data    = '0;
    timeout_hit  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (play && !fifo_full) begin
          state_nxt = ST_REQ;
          load_step = 1'b1;
        end
      end
      ST_REQ: begin
        state_nxt    = ST_WAIT;
        wait_cnt_nxt = '0;
      end
      ST_WAIT: begin
        // A missing answer still yields a (silent) sample so the codec stream keeps its pace.
        if (sample_ready) begin
          push      = 1'b1;
          push_data = sample;
          state_nxt = ST_IDLE;
        end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          push        = 1'b1;
          timeout_hit = 1'b1;
          state_nxt   = ST_IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      step_size    <= '0;
      codec_sample <= '0;
      underrun     <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (load_step) begin
        step_size <= step_size_in;
      end
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end
      if (codec_request) begin
        if (fifo_empty) begin
          codec_sample <= '0;
          underrun     <= 1'b1;
        end else begin
          codec_sample <= fifo_head;
        end
      end
    end
  end

  sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );
endmodule

`default_nettype wire

// File: tb/tb_sine_sample_requester.sv
// ---------------------------------------------------------------------------
// tb_sine_sample_requester : directed bench with a 2-cycle-latency reader model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sine_sample_requester;
  logic        clk = 1'b0;
  logic        reset;
  logic        play;
  logic [19:0] step_size_in;
  logic        generate_next;
  logic [19:0] step_size;
  logic        sample_ready;
  logic [15:0] sample;
  logic        codec_request;
  logic [15:0] codec_sample;
  logic [2:0]  fifo_level;
  logic        underrun;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reader model: answers exactly 2 cycles after generate_next; sample k is 16'h1111*(k+1).
  logic gn_d1 = 1'b0;
  logic gn_d2 = 1'b0;
  logic reader_on = 1'b1;
  int   rd_cnt = 0;
  int   rd_base = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    gn_d1 <= generate_next;
    gn_d2 <= gn_d1;
    if (sample_ready === 1'b1) rd_cnt <= rd_cnt + 1;
  end

  assign sample_ready = gn_d2 & reader_on;
  assign sample       = 16'((rd_cnt - rd_base + 1) * 32'h1111);

  sine_sample_requester #(.FIFO_DEPTH(4), .TIMEOUT(7)) dut (
    .clk           (clk),
    .reset         (reset),
    .play          (play),
    .step_size_in  (step_size_in),
    .generate_next (generate_next),
    .step_size     (step_size),
    .sample_ready  (sample_ready),
    .sample        (sample),
    .codec_request (codec_request),
    .codec_sample  (codec_sample),
    .fifo_level    (fifo_level),
    .underrun      (underrun),
    .timeout_err   (timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one cycle into "cycle 0" (first IDLE decision cycle after reset).
  task automatic do_reset();
    reset = 1'b1;
    play = 1'b0;
    codec_request = 1'b0;
    reader_on = 1'b1;
    tick();
    tick();
    tick();
    reset = 1'b0;
    rd_base = rd_cnt;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    play = 1'b0;
    codec_request = 1'b0;
    step_size_in = 20'hABCDE;
    tick();
    tick();
    n_checks++; if (generate_next !== 1'b0) begin n_fail++; $display("FAIL reset_gn got=%b want=0", generate_next); end
    n_checks++; if (step_size !== 20'h0) begin n_fail++; $display("FAIL reset_step got=%h want=00000", step_size); end
    n_checks++; if (codec_sample !== 16'h0) begin n_fail++; $display("FAIL reset_codec got=%h want=0000", codec_sample); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level got=%0d want=0", fifo_level); end
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun got=%b want=0", underrun); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got=%b want=0", timeout_err); end
  endtask

  task automatic test_fill();
    logic exp_gn;
    do_reset();
    step_size_in = 20'h00400;
    play = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      exp_gn = (cyc == 1 || cyc == 5 || cyc == 9 || cyc == 13);
      n_checks++;
      if (generate_next !== exp_gn) begin
        n_fail++; $display("FAIL fill_gn cycle=%0d got=%b want=%b", cyc, generate_next, exp_gn);
      end
      if (cyc >= 1) begin
        n_checks++;
        if (step_size !== 20'h00400) begin
          n_fail++; $display("FAIL fill_step cycle=%0d got=%h want=00400", cyc, step_size);
        end
      end
      tick();
    end
    n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL fill_level got=%0d want=4", fifo_level); end
  endtask

  task automatic test_pop();
    logic [15:0] exp_s;
    play = 1'b0;
    for (int k = 0; k < 4; k++) begin
      codec_request = 1'b1;
      tick();
      codec_request = 1'b0;
      exp_s = 16'((k + 1) * 32'h1111);
      n_checks++;
      if (codec_sample !== exp_s) begin n_fail++; $display("FAIL pop_data k=%0d got=%h want=%h", k, codec_sample, exp_s); end
      n_checks++;
      if (fifo_level !== 3'(3 - k)) begin n_fail++; $display("FAIL pop_level k=%0d got=%0d want=%0d", k, fifo_level, 3 - k); end
    end
    tick();
    tick();
    n_checks++; if (codec_sample !== 16'h4444) begin n_fail++; $display("FAIL pop_hold got=%h want=4444", codec_sample); end
  endtask

  task automatic test_underrun();
    bit seen = 1'b0;
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL underrun_pre got=%b want=0", underrun); end
    codec_request = 1'b1;
    tick();
    codec_request = 1'b0;
    n_checks++; if (codec_sample !== 16'h0) begin n_fail++; $display("FAIL underrun_data got=%h want=0000", codec_sample); end
    n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_flag got=%b want=1", underrun); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL underrun_level got=%0d want=0", fifo_level); end
    play = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (fifo_level !== 3'd0) seen = 1'b1;
    end
    play = 1'b0;
    n_checks++; if (!seen) begin n_fail++; $display("FAIL underrun_refill got=level0 want=nonzero"); end
    n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_sticky got=%b want=1", underrun); end
  endtask

  task automatic test_timeout();
    bit seen = 1'b0;
    do_reset();
    reader_on = 1'b0;
    play = 1'b1;
    tick();
    n_checks++; if (generate_next !== 1'b1) begin n_fail++; $display("FAIL to_first_gn got=%b want=1", generate_next); end
    play = 1'b0;
    repeat (4) tick();
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_early got=%b want=0", timeout_err); end
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (timeout_err === 1'b1) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL to_flag got=0 want=1"); end
    n_checks++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL to_level got=%0d want=1", fifo_level); end
    reader_on = 1'b1;
    rd_base = rd_cnt;
    play = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      tick();
      if (generate_next === 1'b1) seen = 1'b1;
    end
    play = 1'b0;
    n_checks++; if (!seen) begin n_fail++; $display("FAIL to_next_req got=none want=generate_next"); end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (fifo_level === 3'd2) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL to_second_push got=%0d want=2", fifo_level); end
    codec_request = 1'b1;
    tick();
    n_checks++; if (codec_sample !== 16'h0000) begin n_fail++; $display("FAIL to_pop0 got=%h want=0000", codec_sample); end
    tick();
    codec_request = 1'b0;
    n_checks++; if (codec_sample !== 16'h1111) begin n_fail++; $display("FAIL to_pop1 got=%h want=1111", codec_sample); end
    n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky got=%b want=1", timeout_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    play = 1'b1;
    tick();
    n_checks++; if (generate_next !== 1'b1) begin n_fail++; $display("FAIL rm_gn got=%b want=1", generate_next); end
    play = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL rm_level got=%0d want=0", fifo_level); end
    n_checks++; if (generate_next !== 1'b0) begin n_fail++; $display("FAIL rm_gn_after got=%b want=0", generate_next); end
    n_checks++; if (step_size !== 20'h0) begin n_fail++; $display("FAIL rm_step got=%h want=00000", step_size); end
    n_checks++; if (codec_sample !== 16'h0) begin n_fail++; $display("FAIL rm_codec got=%h want=0000", codec_sample); end
    n_checks++; if (underrun !== 1'b0 || timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL rm_flags got=%b%b want=00", underrun, timeout_err);
    end
    repeat (4) tick();
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL rm_level_late got=%0d want=0", fifo_level); end
  endtask

  task automatic test_simultaneous();
    bit seen = 1'b0;
    logic [15:0] exp_s;
    do_reset();
    play = 1'b1;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (sample_ready === 1'b1 && fifo_level === 3'd3) seen = 1'b1;
      else tick();
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL sim_setup got=level%0d want=3 with sample_ready", fifo_level); end
    codec_request = 1'b1;
    play = 1'b0;
    tick();
    codec_request = 1'b0;
    n_checks++; if (fifo_level !== 3'd3) begin n_fail++; $display("FAIL sim_level got=%0d want=3", fifo_level); end
    n_checks++; if (codec_sample !== 16'h1111) begin n_fail++; $display("FAIL sim_pop0 got=%h want=1111", codec_sample); end
    for (int k = 1; k < 4; k++) begin
      codec_request = 1'b1;
      tick();
      codec_request = 1'b0;
      exp_s = 16'((k + 1) * 32'h1111);
      n_checks++;
      if (codec_sample !== exp_s) begin n_fail++; $display("FAIL sim_pop k=%0d got=%h want=%h", k, codec_sample, exp_s); end
      n_checks++;
      if (fifo_level !== 3'(3 - k)) begin n_fail++; $display("FAIL sim_drain k=%0d got=%0d want=%0d", k, fifo_level, 3 - k); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fill();
    test_pop();
    test_underrun();
    test_timeout();
    test_reset_mid();
    test_simultaneous();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
